top_stream_loader: RTL and testbench
====================================

# top_stream_loader

Upstream DMA sequencer for the int8 MLP `Top` accelerator. It reads pre-packed ifmap, weight and bias words from a word-addressed source SRAM and drives `Top`'s `ready`/`i_en`/`data_in` stream for two passes. It captures each pass's 64 `ofmap` results and writes them back to a result SRAM. In chained mode (mode 1), the pass-0 results are fed back as the pass-1 bias, so the two-layer MLP runs without host intervention.

## Interface
- `IF_WORDS`, default 16: ifmap words per pass (4 int8 each).
- `W_WORDS`, default 1024: weight words per pass.
- `B_WORDS`, default 64: bias words per pass, also the number of ofmap results per pass.
- `PASSES`, default 2: passes per job.
- `ADDR_W`, default 12: source/result address width.
- Ports:
  - `clk` in 1: sole clock.
  - `rst` in 1: asynchronous, active-low reset.
  - `start` in 1: one-cycle job request, sampled in IDLE only.
  - `mode` in 1: 0 = independent passes; 1 = chained (pass-1 bias comes from pass-0 ofmap).
  - `busy` out 1: high from accepting `start` until `done`.
  - `done` out 1: one-cycle pulse at job end.
  - `err` out 1: sticky unexpected-`valid` flag, cleared on `start`.
  - `src_re` out 1, `src_addr` out `ADDR_W`: source SRAM read request.
  - `src_rdata` in 32: read data, fixed 1-cycle latency.
  - `ready` out 1, `i_en` out 1, `data_in` out 32: stream to `Top`.
  - `valid` in 1, `ofmap` in 32: result stream from `Top`.
  - `wb_we` out 1, `wb_addr` out `ADDR_W`, `wb_data` out 32: result SRAM write port.

## Operation
- Source layout: pass p occupies `src_addr` p·S … p·S+S−1, where S = `IF_WORDS`+`W_WORDS`+`B_WORDS` (1104). Within a pass the order is ifmap, then weight, then bias.
- FSM states: IDLE → WAIT_IDLE → RDY → STREAM → DRAIN → (next pass: WAIT_IDLE | last pass: FIN) → IDLE.
- IDLE:
  - On `start`, clear `err`, pass counter, word counter and result counter.
  - Latch `mode`; later changes to `mode` are ignored.
- WAIT_IDLE: hold until `valid`==0.
- RDY:
  - Assert `ready` for exactly one cycle.
  - In the same cycle issue `src_re` for word 0.
- STREAM:
  - Issue one read per cycle for words 1…S−1.
  - `data_in` and `i_en` are registered from `src_rdata`, giving S contiguous `i_en` cycles with no bubbles.
  - Mode 1, pass 1, bias words: `src_re` stays low. The source for bias word k is capture-buffer entry k, registered through the same one-cycle stage so alignment is identical.
- DRAIN: wait until the per-pass result count reaches `B_WORDS`, then advance the pass counter.
- FIN: pulse `done` for one cycle and drop `busy`.
- Capture (valid only in STREAM or DRAIN): each `valid` cycle stores `ofmap` and increments the result counter r (0…63).
  - Mode 0, or pass 1 in mode 1: `wb_we`=1, `wb_addr`=pass·64+r, `wb_data`=`ofmap`, in the same cycle.
  - Mode 1, pass 0: write `ofmap` to the 64×32 capture buffer entry r; no `wb_we`.
- Error cases:
  - `valid` in IDLE, WAIT_IDLE, RDY or FIN: word dropped, `err` set.
  - `valid` when r is already 64: word dropped, `err` set.
- `start` while `busy`: ignored.
- Reset mid-job: every register returns to reset immediately. A partially streamed pass is abandoned; the capture buffer contents are undefined.

## Timing
- Reset values: every output is 0, FSM is in IDLE, counters are 0.
- `start` → WAIT_IDLE in the next cycle. With `valid` low, RDY follows one cycle later.
- First `i_en` occurs in the cycle immediately after the `ready` pulse. The last `i_en` occurs S cycles later.
- `data_in` is valid exactly in cycles where `i_en`=1. Otherwise it is held at 0.
- `wb_*` is combinational from `valid`/`ofmap` plus the registered address: zero latency.
- `done` asserts one cycle after the final ofmap of the last pass is captured.

## Structure
- Shared package `mlp_pkg` holds:
  - the state enum;
  - `IF_WORDS`, `W_WORDS`, `B_WORDS` and the derived stream length S;
  - the mode encoding.
- One natural sub-module, `ofmap_capture_buf`: the 64×32 register file with a write port and a registered read port, used only in mode 1.

## Test plan
- Mode 0, source word n = n, Top model echoes: 1104 contiguous `i_en` cycles per pass. Pass-1 first `data_in` = 1104. 128 `wb_we` writes at addresses 0…127.
- Mode 1, pass-0 ofmap k = 0xA000_0000+k: during pass-1 bias words, `src_re`=0 and `data_in` = 0xA000_0000…0xA000_003F in order. Only 64 writes occur, at addresses 64…127.
- `valid` held high for 3 cycles after `start`: RDY is delayed exactly 3 cycles and `err` is set.
- A 65th `valid` in DRAIN: no write, `err`=1, and `done` still pulses once.
- `rst` asserted at stream word 500, then `start` re-issued: outputs are 0 during reset, and the new job restarts at `src_addr` 0.
- `start` pulsed while `busy`: no effect on counters or addresses.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP accelerator stream loader.
package mlp_pkg;

  localparam int DATA_W     = 32;
  localparam int IF_WORDS   = 16;
  localparam int W_WORDS    = 1024;
  localparam int B_WORDS    = 64;
  localparam int STREAM_LEN = IF_WORDS + W_WORDS + B_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_RDY,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_e;

  typedef enum logic {
    MODE_INDEP = 1'b0,
    MODE_CHAIN = 1'b1
  } mode_e;

endpackage

// File: rtl/top_stream_loader_if.sv
// Stream handshake between the loader and the Top accelerator.
interface top_stream_loader_if;
  logic                        ready;
  logic                        i_en;
  logic [mlp_pkg::DATA_W-1:0]  data_in;
  logic                        valid;
  logic [mlp_pkg::DATA_W-1:0]  ofmap;

  modport master (output ready, i_en, data_in, input valid, ofmap);
  modport slave  (input ready, i_en, data_in, output valid, ofmap);
endinterface

// File: rtl/ofmap_capture_buf.sv
// Pass-0 ofmap holding buffer: one write port, one registered read port.
module ofmap_capture_buf #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/top_stream_loader.sv
// Two-pass DMA sequencer: streams ifmap/weight/bias words into Top and writes
// the ofmap results back; in chained mode pass-0 results become pass-1 bias.
module top_stream_loader #(
  parameter int IF_WORDS = mlp_pkg::IF_WORDS,
  parameter int W_WORDS  = mlp_pkg::W_WORDS,
  parameter int B_WORDS  = mlp_pkg::B_WORDS,
  parameter int PASSES   = 2,
  parameter int ADDR_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                src_re,
  output logic [ADDR_W-1:0]   src_addr,
  input  logic [31:0]         src_rdata,
  top_stream_loader_if.master acc,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [31:0]         wb_data
);
  import mlp_pkg::*;

  localparam int SW    = IF_WORDS + W_WORDS + B_WORDS;
  localparam int BIAS0 = IF_WORDS + W_WORDS;
  localparam int WC_W  = $clog2(SW + 1);
  localparam int RC_W  = $clog2(B_WORDS + 1);
  localparam int PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int BA_W  = $clog2(B_WORDS);

  state_e              state, state_nxt;
  mode_e               mode_q;
  logic [WC_W-1:0]     wc;
  logic [RC_W-1:0]     rc;
  logic [PC_W-1:0]     pc;
  logic [ADDR_W-1:0]   src_base, wb_base;
  logic                vld_p0, buf_sel_p0;
  logic [DATA_W-1:0]   buf_rdata;
  logic [BA_W-1:0]     buf_raddr, buf_waddr;
  logic                accept, issue, in_bias, chained_p1, to_buf, buf_rd;
  logic                cap_win, cap_fire, rc_full, pass_done, last_word, last_pass, err_evt;

  assign accept     = (state == ST_IDLE) && start;
  assign issue      = (state == ST_RDY) || (state == ST_STREAM);
  assign last_word  = (wc == WC_W'(SW - 1));
  assign last_pass  = (pc == PC_W'(PASSES - 1));
  assign in_bias    = (wc >= WC_W'(BIAS0));
  assign chained_p1 = (mode_q == MODE_CHAIN) && (pc != '0);
  assign to_buf     = (mode_q == MODE_CHAIN) && (pc == '0);
  assign buf_rd     = issue && chained_p1 && in_bias;
  assign buf_raddr  = BA_W'(wc - WC_W'(BIAS0));
  assign buf_waddr  = BA_W'(rc);

  // Results are only legal while the pass is streaming or draining.
  assign cap_win    = (state == ST_STREAM) || (state == ST_DRAIN);
  assign rc_full    = (rc == RC_W'(B_WORDS));
  assign cap_fire   = acc.valid && cap_win && !rc_full;
  assign err_evt    = acc.valid && (!cap_win || rc_full);
  // Look ahead by one capture so done lands the cycle after the last result.
  assign pass_done  = rc_full || (cap_fire && (rc == RC_W'(B_WORDS - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start)      state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (!acc.valid) state_nxt = ST_RDY;
      ST_RDY:                       state_nxt = ST_STREAM;
      ST_STREAM:    if (last_word)  state_nxt = ST_DRAIN;
      ST_DRAIN:     if (pass_done)  state_nxt = last_pass ? ST_FIN : ST_WAIT_IDLE;
      ST_FIN:                       state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE) && (state != ST_FIN);
    done      = (state == ST_FIN);
    acc.ready = (state == ST_RDY);
    src_re    = issue && !buf_rd;
    src_addr  = '0;
    if (src_re) src_addr = src_base + ADDR_W'(wc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc       <= '0;
      rc       <= '0;
      pc       <= '0;
      mode_q   <= MODE_INDEP;
      src_base <= '0;
      wb_base  <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        wc       <= '0;
        rc       <= '0;
        pc       <= '0;
        mode_q   <= mode_e'(mode);
        src_base <= '0;
        wb_base  <= '0;
      end else begin
        if (issue)    wc <= wc + WC_W'(1);
        if (cap_fire) rc <= rc + RC_W'(1);
        if ((state == ST_DRAIN) && pass_done) begin
          wc       <= '0;
          rc       <= '0;
          pc       <= pc + PC_W'(1);
          src_base <= src_base + ADDR_W'(SW);
          wb_base  <= wb_base + ADDR_W'(B_WORDS);
        end
      end
      err <= (accept ? 1'b0 : err) | err_evt;
    end
  end

  // ---- p0: read-return stage aligned with SRAM latency ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0     <= 1'b0;
      buf_sel_p0 <= 1'b0;
    end else begin
      vld_p0     <= issue;
      buf_sel_p0 <= buf_rd;
    end
  end

  assign acc.i_en    = vld_p0;
  assign acc.data_in = !vld_p0 ? '0 : (buf_sel_p0 ? buf_rdata : src_rdata);

  assign wb_we   = cap_fire && !to_buf;
  assign wb_addr = wb_we ? (wb_base + ADDR_W'(rc)) : '0;
  assign wb_data = wb_we ? acc.ofmap : '0;

  ofmap_capture_buf #(
    .DEPTH  (B_WORDS),
    .DATA_W (DATA_W)
  ) u_capture_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_fire && to_buf),
    .waddr (buf_waddr),
    .wdata (acc.ofmap),
    .re    (buf_rd),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_top_stream_loader.sv
// Bench for top_stream_loader: SRAM + Top models, randomized jobs, scoreboard.
module tb_top_stream_loader;
  localparam int S      = mlp_pkg::STREAM_LEN;
  localparam int B      = mlp_pkg::B_WORDS;
  localparam int BIAS0  = mlp_pkg::IF_WORDS + mlp_pkg::W_WORDS;
  localparam int PASSES = 2;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic        busy, done, err, src_re, wb_we;
  logic [11:0] src_addr, wb_addr;
  logic [31:0] src_rdata = '0;
  logic [31:0] wb_data;

  top_stream_loader_if acc_if ();

  top_stream_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .src_re    (src_re),
    .src_addr  (src_addr),
    .src_rdata (src_rdata),
    .acc       (acc_if),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] src_mem [4096];
  logic [31:0] res [PASSES][B];

  always @(posedge clk) if (src_re) src_rdata <= src_mem[src_addr];

  logic [31:0] din_q[$];
  int          ien_cyc_q[$];
  int          rdy_q[$];
  logic [11:0] src_q[$];
  logic [11:0] wba_q[$];
  logic [31:0] wbd_q[$];
  int          done_q[$];
  int          nz_idle = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (acc_if.i_en) begin
        din_q.push_back(acc_if.data_in);
        ien_cyc_q.push_back(cyc);
      end else if (acc_if.data_in != 0) nz_idle <= nz_idle + 1;
      if (acc_if.ready) rdy_q.push_back(cyc);
      if (src_re) src_q.push_back(src_addr);
      if (wb_we) begin
        wba_q.push_back(wb_addr);
        wbd_q.push_back(wb_data);
      end
      if (done) done_q.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out_zero(input string tag);
    check_eq({tag, "_ctl"}, 32'({busy, done, err, src_re, acc_if.ready, acc_if.i_en, wb_we}), 32'd0);
    check_eq({tag, "_src_addr"}, 32'(src_addr), 32'd0);
    check_eq({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    check_eq({tag, "_data_in"}, acc_if.data_in, 32'd0);
    check_eq({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) src_mem[i] = $urandom;
    for (int p = 0; p < PASSES; p++)
      for (int k = 0; k < B; k++) res[p][k] = $urandom;
  endtask

  task automatic run_job(input bit md, input int pre_v, input bit extra, input bit poke);
    int ib, rb, sb, wbb, db, nzb, st, lastv, k;
    bit tmo;
    logic [31:0] exp_din[$];
    logic [11:0] exp_src[$];
    logic [11:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    ib = din_q.size(); rb = rdy_q.size(); sb = src_q.size();
    wbb = wba_q.size(); db = done_q.size(); nzb = nz_idle;
    tmo = 1'b0; lastv = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = md; st = cyc;
    @(posedge clk); #1;
    start = 1'b0; mode = ~md;
    if (pre_v > 0) begin
      acc_if.valid = 1'b1; acc_if.ofmap = $urandom;
      repeat (pre_v) @(posedge clk);
      #1 acc_if.valid = 1'b0;
    end
    for (int p = 0; p < PASSES; p++) begin
      int w = 0;
      while (!tmo && (din_q.size() - ib) < (p + 1) * S) begin
        start = poke && ((din_q.size() - ib) == p * S + 300);
        if (start) mode = ~mode;
        @(posedge clk); #1;
        w++;
        if (w > 4000) begin
          tmo = 1'b1;
          check_eq("stream_len", din_q.size() - ib, (p + 1) * S);
        end
      end
      start = 1'b0;
      if (tmo) break;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      for (int j = 0; j < B; j++) begin
        acc_if.valid = 1'b1; acc_if.ofmap = res[p][j];
        if (p == PASSES - 1 && j == B - 1) lastv = cyc;
        @(posedge clk); #1;
        acc_if.valid = 1'b0;
        if (j != B - 1 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      if (extra && p == PASSES - 1) begin
        acc_if.valid = 1'b1; acc_if.ofmap = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        acc_if.valid = 1'b0;
      end
    end
    k = 0;
    while (done_q.size() == db && k < 50) begin @(posedge clk); #1; k++; end
    repeat (3) begin @(posedge clk); #1; end

    // Reference: what the job should have produced, from the layout rules.
    for (int p = 0; p < PASSES; p++)
      for (int n = 0; n < S; n++)
        if (md && p > 0 && n >= BIAS0) exp_din.push_back(res[p-1][n-BIAS0]);
        else begin
          exp_din.push_back(src_mem[p*S+n]);
          exp_src.push_back(12'(p*S+n));
        end
    for (int p = 0; p < PASSES; p++)
      if (!(md && p == 0))
        for (int j = 0; j < B; j++) begin
          exp_wa.push_back(12'(p*B+j));
          exp_wd.push_back(res[p][j]);
        end

    check_eq("rdy_cnt", rdy_q.size() - rb, PASSES);
    if (rdy_q.size() - rb == PASSES) begin
      check_eq("rdy0_cyc", rdy_q[rb], st + 2 + pre_v);
      if (din_q.size() - ib == PASSES * S)
        for (int p = 0; p < PASSES; p++) begin
          check_eq($sformatf("ien_first_p%0d", p), ien_cyc_q[ib+p*S], rdy_q[rb+p] + 1);
          check_eq($sformatf("ien_last_p%0d", p), ien_cyc_q[ib+p*S+S-1], rdy_q[rb+p] + S);
        end
    end
    check_eq("din_cnt", din_q.size() - ib, exp_din.size());
    if (din_q.size() - ib == exp_din.size())
      for (int i = 0; i < exp_din.size(); i++)
        check_eq($sformatf("din[%0d]", i), din_q[ib+i], exp_din[i]);
    check_eq("src_cnt", src_q.size() - sb, exp_src.size());
    if (src_q.size() - sb == exp_src.size())
      for (int i = 0; i < exp_src.size(); i++)
        check_eq($sformatf("src_addr[%0d]", i), 32'(src_q[sb+i]), 32'(exp_src[i]));
    check_eq("wb_cnt", wba_q.size() - wbb, exp_wa.size());
    if (wba_q.size() - wbb == exp_wa.size())
      for (int i = 0; i < exp_wa.size(); i++) begin
        check_eq($sformatf("wb_addr[%0d]", i), 32'(wba_q[wbb+i]), 32'(exp_wa[i]));
        check_eq($sformatf("wb_data[%0d]", i), wbd_q[wbb+i], exp_wd[i]);
      end
    check_eq("done_cnt", done_q.size() - db, 1);
    if (done_q.size() > db) check_eq("done_cyc", done_q[db], lastv + 1);
    check_eq("err", 32'(err), 32'((pre_v > 0) || extra));
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("din_idle_nz", nz_idle - nzb, 0);
  endtask

  initial begin
    int k, ib;
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    acc_if.valid = 1'b0; acc_if.ofmap = '0;
    #12;
    check_out_zero("reset");
    rst = 1'b1;

    // Mode 0 with source word n = n, start poked mid-stream.
    for (int i = 0; i < 4096; i++) src_mem[i] = i;
    for (int p = 0; p < PASSES; p++)
      for (int j = 0; j < B; j++) res[p][j] = $urandom;
    run_job(1'b0, 0, 1'b0, 1'b1);

    // Chained mode with recognisable pass-0 results.
    fill_random();
    for (int j = 0; j < B; j++) res[0][j] = 32'hA000_0000 + j;
    run_job(1'b1, 0, 1'b0, 1'b1);

    // Stale valid after start delays RDY and flags err.
    fill_random();
    run_job(1'b0, 3, 1'b0, 1'b0);

    // Surplus result after the last one of the job.
    fill_random();
    run_job(1'b1, 0, 1'b1, 1'b0);

    // Reset in the middle of pass 0, then a fresh job.
    fill_random();
    ib = din_q.size();
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ((din_q.size() - ib) < 500 && k < 3000) begin @(posedge clk); #1; k++; end
    check_eq("pre_rst_words", din_q.size() - ib, 500);
    rst = 1'b0;
    #2 check_out_zero("rst_mid");
    repeat (2) begin @(posedge clk); #1; end
    check_out_zero("rst_hold");
    rst = 1'b1;
    @(posedge clk); #1;
    fill_random();
    run_job(1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
